// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide, one bit per cycle, fixed WIDTH+2 latency
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, mb_q, mb_d, a_q, a_d, result_q, result_d;
  logic neg_q, neg_d, sa_q, sa_d, dz_q, dz_d, ovf_q, ovf_d, done_q, done_d;
  logic sa, sb, ge;
  logic [WIDTH-1:0] ma, mbv, diff, quo, rem, fin;
  logic [WIDTH:0] sum, t;
  logic [2*WIDTH-1:0] prod;
  always_comb begin
    sa = funct3 inside {3'b001, 3'b010, 3'b100, 3'b110} && a[WIDTH-1];
    sb = funct3 inside {3'b001, 3'b100, 3'b110} && b[WIDTH-1];
    ma = sa ? -a : a;
    mbv = sb ? -b : b;
    sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mb_q} : '0);
    t = {hi_q, lo_q[WIDTH-1]};
    ge = t >= {1'b0, mb_q};
    diff = t[WIDTH-1:0] - mb_q;
    prod = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo = neg_q ? -lo_q : lo_q;
    rem = sa_q ? -hi_q : hi_q;
    // hi/lo hold the product for multiplies, remainder/quotient for divides
    fin = !op_q[2] ? (op_q[1:0] == 2'b00 ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH])
        : dz_q ? (op_q[1] ? a_q : '1)
        : ovf_q ? (op_q[1] ? '0 : a_q)
        : op_q[1] ? rem : quo;
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    hi_d = hi_q;
    lo_d = lo_q;
    mb_d = mb_q;
    a_d = a_q;
    neg_d = neg_q;
    sa_d = sa_q;
    dz_d = dz_q;
    ovf_d = ovf_q;
    result_d = result_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start && !flush) begin
        state_d = CALC;
        cnt_d = '0;
        op_d = funct3;
        hi_d = '0;
        lo_d = ma;
        mb_d = mbv;
        a_d = a;
        neg_d = sa ^ sb;
        sa_d = sa;
        dz_d = b == '0;
        ovf_d = funct3[2] && !funct3[0] && a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1;
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        hi_d = op_q[2] ? (ge ? diff : t[WIDTH-1:0]) : sum[WIDTH:1];
        lo_d = op_q[2] ? {lo_q[WIDTH-2:0], ge} : {sum[0], lo_q[WIDTH-1:1]};
        state_d = flush ? IDLE : cnt_q == CW'(WIDTH-1) ? FIN : CALC;
      end
      FIN: begin
        state_d = IDLE;
        result_d = flush ? result_q : fin;
        done_d = !flush;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      mb_q <= '0;
      a_q <= '0;
      neg_q <= 1'b0;
      sa_q <= 1'b0;
      dz_q <= 1'b0;
      ovf_q <= 1'b0;
      result_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      mb_q <= mb_d;
      a_q <= a_d;
      neg_q <= neg_d;
      sa_q <= sa_d;
      dz_q <= dz_d;
      ovf_q <= ovf_d;
      result_q <= result_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign result = result_q;
endmodule
